// File: rtl/izh_step_scheduler_if.sv
// Bundle between the step scheduler, its timestep controller and the shared Izhikevich datapath.
// Optional state read-back signals exist only when IZH_STATE_RD_EN is defined.
interface izh_step_scheduler_if #(
    parameter int N_NEURONS = 16,
    parameter int IDX_W     = 4
);
    logic                 step_start;
    logic                 busy;
    logic                 done;
    logic                 cfg_we;
    logic [1:0]           cfg_addr;
    logic [16:0]          cfg_data;
    logic [IDX_W-1:0]     i_addr;
    logic [16:0]          i_data;
    logic [16:0]          dp_a, dp_b, dp_c, dp_d;
    logic [16:0]          dp_v, dp_u, dp_i;
    logic [16:0]          dp_v_prime, dp_u_prime;
    logic                 dp_fired;
    logic [N_NEURONS-1:0] spike_vec;
    logic [IDX_W:0]       spike_count;
`ifdef IZH_STATE_RD_EN
    logic [IDX_W-1:0]     rd_addr;
    logic [16:0]          rd_v, rd_u;

    modport slave (
        input  step_start, cfg_we, cfg_addr, cfg_data, i_data,
               dp_v_prime, dp_u_prime, dp_fired, rd_addr,
        output busy, done, i_addr, dp_a, dp_b, dp_c, dp_d,
               dp_v, dp_u, dp_i, spike_vec, spike_count, rd_v, rd_u
    );
    modport master (
        output step_start, cfg_we, cfg_addr, cfg_data, i_data,
               dp_v_prime, dp_u_prime, dp_fired, rd_addr,
        input  busy, done, i_addr, dp_a, dp_b, dp_c, dp_d,
               dp_v, dp_u, dp_i, spike_vec, spike_count, rd_v, rd_u
    );
`else
    modport slave (
        input  step_start, cfg_we, cfg_addr, cfg_data, i_data,
               dp_v_prime, dp_u_prime, dp_fired,
        output busy, done, i_addr, dp_a, dp_b, dp_c, dp_d,
               dp_v, dp_u, dp_i, spike_vec, spike_count
    );
    modport master (
        output step_start, cfg_we, cfg_addr, cfg_data, i_data,
               dp_v_prime, dp_u_prime, dp_fired,
        input  busy, done, i_addr, dp_a, dp_b, dp_c, dp_d,
               dp_v, dp_u, dp_i, spike_vec, spike_count
    );
`endif
endinterface

// File: rtl/izh_step_scheduler.sv
// Sweeps one shared Izhikevich datapath over N_NEURONS neurons per timestep (2 cycles per neuron).
// Define IZH_STATE_RD_EN to add a registered v/u read-back port (rd_addr/rd_v/rd_u).
module izh_step_scheduler #(
    parameter int          N_NEURONS = 16,
    parameter int          IDX_W     = 4,
    parameter logic [16:0] V_INIT    = 17'h1_4100,
    parameter logic [16:0] U_INIT    = 17'h1_0D00
) (
    input  logic                clk,
    input  logic                rst,
    izh_step_scheduler_if.slave sched
);
    typedef enum logic [1:0] {IDLE, LOAD, CAPT, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [IDX_W-1:0]     i_addr_q;
    logic [16:0]          v_mem_q [N_NEURONS];
    logic [16:0]          u_mem_q [N_NEURONS];
    logic [16:0]          cfg_a_q, cfg_b_q, cfg_c_q, cfg_d_q;
    logic [16:0]          dp_v_q, dp_u_q, dp_i_q;
    logic                 busy_q, done_q;
    logic [N_NEURONS-1:0] spike_acc_q, spike_vec_q;
    logic [IDX_W:0]       count_acc_q, spike_count_q;

    assign idx_d = idx_q + 1'b1;

    // i_addr runs one step ahead of idx outside LOAD, so i_data is already valid
    // for the neuron being loaded when dp_i is captured on LOAD entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            i_addr_q      <= '0;
            cfg_a_q       <= 17'h0_0005;
            cfg_b_q       <= 17'h0_0033;
            cfg_c_q       <= 17'h1_4100;
            cfg_d_q       <= 17'h0_0800;
            dp_v_q        <= '0;
            dp_u_q        <= '0;
            dp_i_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            spike_acc_q   <= '0;
            spike_vec_q   <= '0;
            count_acc_q   <= '0;
            spike_count_q <= '0;
            for (int k = 0; k < N_NEURONS; k++) begin
                v_mem_q[k] <= V_INIT;
                u_mem_q[k] <= U_INIT;
            end
        end else begin
            if (state_q == IDLE && sched.cfg_we) begin
                case (sched.cfg_addr)
                    2'd0:    cfg_a_q <= sched.cfg_data;
                    2'd1:    cfg_b_q <= sched.cfg_data;
                    2'd2:    cfg_c_q <= sched.cfg_data;
                    default: cfg_d_q <= sched.cfg_data;
                endcase
            end

            case (state_q)
                IDLE: begin
                    if (sched.step_start) begin
                        state_q     <= LOAD;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        spike_acc_q <= '0;
                        count_acc_q <= '0;
                        dp_v_q      <= v_mem_q[0];
                        dp_u_q      <= u_mem_q[0];
                        dp_i_q      <= sched.i_data;
                    end
                end
                LOAD: begin
                    state_q  <= CAPT;
                    i_addr_q <= (idx_q == LAST_IDX) ? '0 : idx_d;
                end
                CAPT: begin
                    v_mem_q[idx_q]     <= sched.dp_v_prime;
                    u_mem_q[idx_q]     <= sched.dp_u_prime;
                    spike_acc_q[idx_q] <= sched.dp_fired;
                    count_acc_q        <= count_acc_q + (IDX_W+1)'(sched.dp_fired);
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= LOAD;
                        idx_q   <= idx_d;
                        dp_v_q  <= v_mem_q[idx_d];
                        dp_u_q  <= u_mem_q[idx_d];
                        dp_i_q  <= sched.i_data;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b0;
                    spike_vec_q   <= spike_acc_q;
                    spike_count_q <= count_acc_q;
                end
            endcase
        end
    end

    assign sched.busy        = busy_q;
    assign sched.done        = done_q;
    assign sched.i_addr      = i_addr_q;
    assign sched.dp_a        = cfg_a_q;
    assign sched.dp_b        = cfg_b_q;
    assign sched.dp_c        = cfg_c_q;
    assign sched.dp_d        = cfg_d_q;
    assign sched.dp_v        = dp_v_q;
    assign sched.dp_u        = dp_u_q;
    assign sched.dp_i        = dp_i_q;
    assign sched.spike_vec   = spike_vec_q;
    assign sched.spike_count = spike_count_q;

`ifdef IZH_STATE_RD_EN
    logic [16:0] rd_v_q, rd_u_q;

    // A read colliding with a write-back returns the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v_q <= '0;
            rd_u_q <= '0;
        end else begin
            rd_v_q <= v_mem_q[sched.rd_addr];
            rd_u_q <= u_mem_q[sched.rd_addr];
        end
    end

    assign sched.rd_v = rd_v_q;
    assign sched.rd_u = rd_u_q;
`endif
endmodule

// File: doc/izh_step_scheduler.md
Name: izh_step_scheduler

Overview:
Time-multiplexes one izhikevich neuron datapath across N_NEURONS neurons. Holds per-neuron v/u state and shared a/b/c/d configuration. On each simulation timestep pulse it walks every neuron index in order. For each neuron it drives the datapath, captures v_prime/u_prime/fired and writes them back. It sits between the network-level timestep controller and the single izhikevich instance.

Parameters:
N_NEURONS, 16, number of neurons sequenced per timestep (2..256)
IDX_W, 4, neuron index width, clog2(N_NEURONS)
V_INIT, 17'h1_4100, reset value of every v entry (-65.0)
U_INIT, 17'h1_0D00, reset value of every u entry (-13.0)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
step_start  in  1  one-cycle pulse: run one timestep over all neurons
busy  out  1  high while a timestep sweep is in progress
done  out  1  one-cycle pulse when the sweep completes
cfg_we  in  1  configuration write strobe
cfg_addr  in  2  0=a 1=b 2=c 3=d
cfg_data  in  17  configuration value
i_addr  out  IDX_W  neuron index whose input current is requested
i_data  in  17  input current for i_addr, valid combinationally in the same cycle
dp_a, dp_b, dp_c, dp_d  out  17 each  configuration to datapath
dp_v, dp_u, dp_i  out  17 each  operands to datapath
dp_v_prime, dp_u_prime  in  17 each  registered datapath results
dp_fired  in  1  registered datapath spike flag
spike_vec  out  N_NEURONS  spike flags of the last completed timestep, bit k = neuron k
spike_count  out  IDX_W+1  number of set bits in spike_vec

Behaviour:
- Number format: 17-bit sign-magnitude. Bit16 is the sign; bits 15:0 are Q8.8 magnitude. No arithmetic is done here except the spike_count increment.
- Reset values:
  - a=17'h0_0005, b=17'h0_0033, c=17'h1_4100, d=17'h0_0800.
  - All v=V_INIT, all u=U_INIT.
  - busy=0, done=0, spike_vec=0, spike_count=0, i_addr=0, dp_v/dp_u/dp_i=0.
- dp_a..dp_d are continuous copies of the config registers.
- State storage: two register arrays v_mem[N_NEURONS], u_mem[N_NEURONS], plus an index counter idx.
- FSM states IDLE, LOAD, CAPT, DONE.
  - IDLE:
    - step_start=1 -> LOAD, idx=0, busy=1, temporary spike accumulators cleared.
    - Otherwise stay in IDLE.
  - LOAD:
    - i_addr=idx.
    - dp_v=v_mem[idx], dp_u=u_mem[idx], dp_i=i_data; all three are registered on entry so they are stable for the whole cycle.
    - Next state is CAPT. The datapath registers its result at the LOAD->CAPT edge.
  - CAPT:
    - On the CAPT exit edge: v_mem[idx] <= dp_v_prime, u_mem[idx] <= dp_u_prime, spike_acc[idx] <= dp_fired, count_acc += dp_fired.
    - idx==N_NEURONS-1 -> DONE; otherwise idx+1 and return to LOAD.
  - DONE:
    - done=1 for exactly one cycle.
    - spike_vec <= spike_acc, spike_count <= count_acc.
    - busy drops with done; next state is IDLE.
- Latency: step_start sampled at edge T. busy is high from T+1 through T+2N+1 inclusive; done is high in cycle T+2N+1. Each neuron takes 2 cycles.
- Boundaries:
  - step_start while busy: ignored, not queued.
  - step_start in the DONE cycle: ignored.
  - cfg_we while busy: ignored, so configuration is constant across a sweep. cfg_we while idle updates the register at the next edge.
  - idx never exceeds N_NEURONS-1; no wrap past the last index.
  - spike_vec and spike_count hold their values between sweeps and change only in the DONE cycle.
  - rst at any cycle, including mid-sweep: all state returns to reset values at that edge and the partial sweep is discarded.

Optional Feature:
Macro IZH_STATE_RD_EN.
- Defined: adds ports rd_addr in IDX_W, rd_v out 17, rd_u out 17.
  - rd_v/rd_u return v_mem[rd_addr]/u_mem[rd_addr] registered with one-cycle latency.
  - Reads are allowed while busy; a read of the entry being written returns the pre-write value.
  - rd_v/rd_u reset to 0.
- Not defined: the ports do not exist and no read mux is built.

Test Plan:
- Reset, then idle 3 cycles -> busy=0, done=0, spike_vec=0, spike_count=0, dp_a=17'h0_0005, dp_c=17'h1_4100.
- cfg_we with addr 3, data 17'h0_0400 while idle -> dp_d=17'h0_0400 next cycle. Same write during busy -> dp_d unchanged.
- N_NEURONS=4 with a stub datapath (v_prime=v+1 LSB, u_prime=u, fired when idx==2), step_start at T:
  - LOAD of neuron 0 shows dp_v=17'h1_4100.
  - done at T+9.
  - spike_vec=4'b0100, spike_count=1.
  - Second sweep shows dp_v=17'h1_40FF for neuron 0.
- i_data driven as 17'h0_0A00 + i_addr -> in each LOAD cycle dp_i equals 17'h0_0A00 + idx.
- step_start pulsed again at T+3 of a sweep -> ignored: single done at T+9, no second busy period.
- rst asserted at T+4 of a sweep -> next cycle busy=0, v_mem all V_INIT, spike_vec=0. A fresh step_start then completes normally in 2N+1 cycles.
